// File: rtl/multi_digit_counter_pkg.sv
// multi_digit_counter_pkg
//   Shared constants for the multi-digit counter:
//   - DIGIT_W    : width of one counter digit (4)
//   - SEG_0..F   : active-low {g,f,e,d,c,b,a} patterns for hex digits
//   - SEG_BLANK  : all segments off
//   - seg_encode : 4-bit digit -> 7-bit active-low segment pattern
package multi_digit_counter_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0011000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [DIGIT_W-1:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multi_digit_counter_seg7_decoder.sv
// seg7_decoder
//   Purely combinational hex digit to 7-segment decoder.
//   Ports:
//     digit : in  4-bit digit value
//     seg   : out active-low segments {g,f,e,d,c,b,a}
module seg7_decoder
    import multi_digit_counter_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [6:0]         seg
);

    assign seg = seg_encode(digit);

endmodule

// File: rtl/multi_digit_counter.sv
// multi_digit_counter
//   Prescaled up/down counter of DIGITS 4-bit digits (hex or BCD) with a
//   7-segment output per digit and a registered wrap pulse.
//   Parameters: DIGITS (1..8), BCD (0 hex / 1 decimal), PRESCALE (1..65536)
//   Ports:
//     Clock   : in  rising-edge clock
//     Resetn  : in  asynchronous active-low reset
//     Clear   : in  synchronous clear (highest priority)
//     En      : in  count enable (freezes prescaler and count when low)
//     Up      : in  1 = up, 0 = down, sampled on the step edge
//     Load    : in  synchronous parallel load (BCD digits clamped to 9)
//     LoadVal : in  load value, digit i in [4i+3:4i]
//     Count   : out registered count
//     Seg     : out active-low segments, digit i in [7i+6:7i]
//     Wrap    : out one-cycle pulse after an all-max <-> all-zero step
//   Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
//   (digit 0 is always shown).
module multi_digit_counter
    import multi_digit_counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int BCD      = 0,
    parameter int PRESCALE = 1
) (
    input  logic                        Clock,
    input  logic                        Resetn,
    input  logic                        Clear,
    input  logic                        En,
    input  logic                        Up,
    input  logic                        Load,
    input  logic [DIGIT_W*DIGITS-1:0]   LoadVal,
    output logic [DIGIT_W*DIGITS-1:0]   Count,
    output logic [7*DIGITS-1:0]         Seg,
    output logic                        Wrap
);

    localparam int unsigned     PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);
    localparam logic [3:0]      DMAX    = (BCD != 0) ? 4'd9 : 4'hF;

    logic [PW-1:0]               ps;
    logic                        step;
    logic [DIGIT_W*DIGITS-1:0]   stepped;
    logic [DIGIT_W*DIGITS-1:0]   clamped;
    logic                        wrap_step;
    logic                        carry;
    logic [3:0]                  d;
    logic [3:0]                  nd;

    assign step = En && (ps == PS_LAST);

    // Ripple carry/borrow through the digits; a carry out of the top digit
    // means every digit rolled over, i.e. the counter wrapped.
    always_comb begin
        stepped = '0;
        carry   = 1'b1;
        d       = '0;
        nd      = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d  = Count[DIGIT_W*i +: DIGIT_W];
            nd = d;
            if (carry) begin
                if (Up) begin
                    if (d == DMAX) begin
                        nd = '0;
                    end else begin
                        nd    = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        nd = DMAX;
                    end else begin
                        nd    = d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            stepped[DIGIT_W*i +: DIGIT_W] = nd;
        end
        wrap_step = carry;
    end

    always_comb begin
        clamped = LoadVal;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((BCD != 0) && (LoadVal[DIGIT_W*i +: DIGIT_W] > 4'd9)) begin
                clamped[DIGIT_W*i +: DIGIT_W] = 4'd9;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Count <= '0;
            ps    <= '0;
            Wrap  <= 1'b0;
        end else if (Clear) begin
            Count <= '0;
            ps    <= '0;
            Wrap  <= 1'b0;
        end else if (Load) begin
            Count <= clamped;
            ps    <= '0;
            Wrap  <= 1'b0;
        end else if (step) begin
            Count <= stepped;
            ps    <= '0;
            Wrap  <= wrap_step;
        end else begin
            if (En) begin
                ps <= ps + PW'(1);
            end
            Wrap <= 1'b0;
        end
    end

    logic [6:0] dec_seg [DIGITS];

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank;

    // Scan from the top digit down; a digit is blank while it and every
    // digit above it are zero. Digit 0 is never blanked.
    always_comb begin
        logic        nz;
        int unsigned idx;
        blank = '0;
        nz    = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
            idx = DIGITS - 1 - k;
            if (Count[DIGIT_W*idx +: DIGIT_W] != 4'd0) begin
                nz = 1'b1;
            end
            blank[idx] = !nz;
        end
    end
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_decoder u_dec (
            .digit (Count[DIGIT_W*g +: DIGIT_W]),
            .seg   (dec_seg[g])
        );
`ifdef LEADING_ZERO_BLANK_EN
        assign Seg[7*g +: 7] = blank[g] ? SEG_BLANK : dec_seg[g];
`else
        assign Seg[7*g +: 7] = dec_seg[g];
`endif
    end

endmodule

// File: doc/multi_digit_counter.md
MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of 4-bit digits, range 1..8.
REQ-002 Parameter BCD, default 0: 0 = hexadecimal digits (0..F); 1 = decimal digits (0..9).
REQ-003 Parameter PRESCALE, default 1: enabled clock cycles per count step, range 1..2^16.
REQ-004 Clock  input  1  single clock, rising edge.
REQ-005 Resetn  input  1  reset, asynchronous, active-low.
REQ-006 Clear  input  1  synchronous clear to zero.
REQ-007 En  input  1  count enable.
REQ-008 Up  input  1  1 = count up, 0 = count down.
REQ-009 Load  input  1  synchronous parallel load.
REQ-010 LoadVal  input  4*DIGITS  load value; digit i in bits [4i+3:4i].
REQ-011 Count  output  4*DIGITS  registered count value.
REQ-012 Seg  output  7*DIGITS  active-low segments {g,f,e,d,c,b,a} per digit; digit i in bits [7i+6:7i].
REQ-013 Wrap  output  1  registered one-cycle pulse on count wrap.

Function
REQ-014 Priority per rising edge: Clear > Load > count step > hold.
REQ-015 Clear: Count=0, prescaler=0, Wrap=0 on the next edge.
REQ-016 Load: Count=LoadVal, prescaler=0, Wrap=0; with BCD=1, any loaded digit >9 is clamped to 9.
REQ-017 Prescaler: counts En-high cycles 0..PRESCALE-1; a count step occurs on the edge where prescaler=PRESCALE-1 and En=1, then prescaler returns to 0.
REQ-018 En=0 freezes the prescaler and Count; prescaler progress is kept, not discarded.
REQ-019 PRESCALE=1: a step on every edge with En=1.
REQ-020 Up step: digit 0 increments; a digit at max (F, or 9 when BCD=1) goes to 0 and carries into the next digit.
REQ-021 Down step: digit 0 decrements; a digit at 0 goes to max and borrows from the next digit.
REQ-022 Wrap=1 for exactly one cycle after an up step from all-max to all-zero, or a down step from all-zero to all-max; otherwise Wrap=0.
REQ-023 Up may change between steps; direction is sampled only on the step edge.
REQ-024 Seg is combinational from Count, with zero latency; encoding 0..F = 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.

Reset
REQ-025 Resetn=0 asynchronously forces Count=0, prescaler=0, Wrap=0, so Seg shows all-zero digits (as modified by REQ-027).
REQ-026 Reset asserted mid-step aborts the step; the first step after release needs a full PRESCALE enabled cycles.

Configuration
REQ-027 With macro LEADING_ZERO_BLANK_EN defined: every digit above the most significant nonzero digit drives Seg=1111111; digit 0 is never blanked.
REQ-028 Without LEADING_ZERO_BLANK_EN: all digits are always displayed; Count and Wrap behaviour are identical in both builds.

Structure
REQ-029 Shared package holds the 7-bit segment constants for 0..F, SEG_BLANK=1111111, and the digit-width constant 4.
REQ-030 A single sub-module seg7_decoder (4-bit in, 7-bit active-low out) is instantiated DIGITS times.
REQ-031 Counter and prescaler are in the top module; there is no other hierarchy.

Verification
REQ-032 Test 1 (DIGITS=4, BCD=0, PRESCALE=1): reset, then En=1 Up=1 for 0x10000 cycles -> Count passes 0xFFFF to 0x0000; Wrap is high for one cycle only; Seg digit 0 at count 0xA = 0001000.
REQ-033 Test 2 (BCD=1): Load 9999, then one up step -> Count=0000 and Wrap pulses; Load 0000, then one down step -> Count=9999 and Wrap pulses; LoadVal=0x00AB loads as 0x0099.
REQ-034 Test 3 (PRESCALE=3): En=1 for 5 cycles, En=0 for 4 cycles, then En=1 for 1 cycle -> Count goes 0 to 1 after the 3rd enabled cycle and 1 to 2 after the 6th enabled cycle.
REQ-035 Test 4: Clear=1, Load=1 and En=1 on the same edge with Count=0x1234 -> Count=0x0000; Load=1 with En=1 and LoadVal=0x00FF -> Count=0x00FF, no step that cycle.
REQ-036 Test 5: Resetn pulsed low between clock edges at Count=0x0042 -> Count=0 immediately, with no clock edge.
REQ-037 Test 6 (LEADING_ZERO_BLANK_EN defined): Count=0x0042 -> digits 3 and 2 show 1111111, digit 1 shows 0011001, digit 0 shows 0100100; Count=0 -> only digit 0 lit, showing 1000000.
